// File: rtl/dp_ram_if.sv
// Bus bundle for dp_ram: write port, read port and status outputs.
interface dp_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                    chip_sel;
  logic                    write_enable;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic                    read_enable;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    rd_valid;
  logic                    init_busy;

  modport master (
    output chip_sel, write_enable, wr_addr, data_in, byte_en,
           read_enable, rd_addr,
    input  data_out, rd_valid, init_busy
  );

  modport slave (
    input  chip_sel, write_enable, wr_addr, data_in, byte_en,
           read_enable, rd_addr,
    output data_out, rd_valid, init_busy
  );
endinterface

// File: rtl/dp_ram.sv
// Simple-dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write behaviour and a post-reset clear sequencer.
//
// state | meaning
// IDLE  | normal operation, both ports accept accesses
// CLEAR | zeroing mem[clr_cnt] one word per cycle, accesses ignored
module dp_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic     ck,
  input  logic     rst,
  dp_ram_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_acc, rd_acc;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_word, rdw_word;

  assign bus.init_busy = (state == CLEAR);
  assign wr_in_range   = {1'b0, bus.wr_addr} < DEPTH_L;
  assign rd_in_range   = {1'b0, bus.rd_addr} < DEPTH_L;
  assign wr_acc = bus.chip_sel & bus.write_enable & ~bus.init_busy & wr_in_range;
  assign rd_acc = bus.chip_sel & bus.read_enable & ~bus.init_busy;
  assign rd_word = mem[bus.rd_addr];

  // Clear sequencer state and address counter.
  always_ff @(posedge ck) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Clear sequencer next state: one word per cycle, leave after the last word.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      IDLE: ;
      CLEAR: begin
        clr_we      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read word with same-address write lanes forwarded when new-data mode is chosen.
  always_comb begin
    rdw_word = rd_word;
    for (int i = 0; i < NB; i++) begin
      if ((RDW_MODE != 0) && wr_acc && (bus.wr_addr == bus.rd_addr) && bus.byte_en[i])
        rdw_word[8*i +: 8] = bus.data_in[8*i +: 8];
    end
  end

  // Array update: clear sequencer has the port while busy, otherwise masked writes.
  always_ff @(posedge ck) begin
    if (clr_we && !rst) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.byte_en[i])
          mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
      end
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge ck) begin
    if (rst) begin
      bus.data_out <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_acc;
      if (rd_acc)
        bus.data_out <= rd_in_range ? rdw_word : '0;
    end
  end
endmodule

// File: tb/tb_dp_ram.sv
// Testbench for dp_ram: a default 16x8 old-data instance and a
// 10x32 new-data instance, checked cycle by cycle through scoreboards.
module tb_dp_ram;
  logic ck = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 ck = ~ck;

  dp_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) bus_a ();
  dp_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus_b ();

  dp_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RDW_MODE(0),
           .CLEAR_ON_RESET(1)) u_a (.ck(ck), .rst(rst_a), .bus(bus_a));

  dp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(10), .RDW_MODE(1),
           .CLEAR_ON_RESET(1)) u_b (.ck(ck), .rst(rst_b), .bus(bus_b));

  typedef struct {
    logic        vld;
    logic        busy;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    bit          cs;
    bit          we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    bit          be;
    bit          re;
    logic [3:0]  ra;
    bit          ev;
    logic [7:0]  ed;
  } vec_a_t;

  sb_t q_a[$];
  sb_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  int          left_a = 0, left_b = 0;
  logic [31:0] last_a = '0, last_b = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of instance A and queue what it must show after the edge.
  task automatic drv_a(input bit r, input bit cs, input bit we, input logic [3:0] wa,
                       input logic [7:0] wd, input bit be, input bit re,
                       input logic [3:0] ra, input bit ev, input logic [7:0] ed);
    sb_t e;
    @(negedge ck);
    rst_a              = r;
    bus_a.chip_sel     = cs;
    bus_a.write_enable = we;
    bus_a.wr_addr      = wa;
    bus_a.data_in      = wd;
    bus_a.byte_en      = be;
    bus_a.read_enable  = re;
    bus_a.rd_addr      = ra;
    if (r) begin
      left_a = 16;
      last_a = '0;
      e.vld  = 1'b0;
    end else begin
      if (left_a > 0) left_a--;
      if (ev) last_a = {24'h0, ed};
      e.vld = ev;
    end
    e.busy = (left_a > 0);
    e.data = last_a;
    q_a.push_back(e);
  endtask

  task automatic drv_b(input bit r, input bit cs, input bit we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] be, input bit re,
                       input logic [3:0] ra, input bit ev, input logic [31:0] ed);
    sb_t e;
    @(negedge ck);
    rst_b              = r;
    bus_b.chip_sel     = cs;
    bus_b.write_enable = we;
    bus_b.wr_addr      = wa;
    bus_b.data_in      = wd;
    bus_b.byte_en      = be;
    bus_b.read_enable  = re;
    bus_b.rd_addr      = ra;
    if (r) begin
      left_b = 10;
      last_b = '0;
      e.vld  = 1'b0;
    end else begin
      if (left_b > 0) left_b--;
      if (ev) last_b = ed;
      e.vld = ev;
    end
    e.busy = (left_b > 0);
    e.data = last_b;
    q_b.push_back(e);
  endtask

  // Scoreboard monitors: compare one queued expectation per clock, 1 ns after the edge.
  always @(posedge ck) begin
    sb_t e;
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_rd_valid",  {31'h0, bus_a.rd_valid},  {31'h0, e.vld});
      check("a_init_busy", {31'h0, bus_a.init_busy}, {31'h0, e.busy});
      check("a_data_out",  {24'h0, bus_a.data_out},  e.data);
    end
  end

  always @(posedge ck) begin
    sb_t e;
    #1;
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_rd_valid",  {31'h0, bus_b.rd_valid},  {31'h0, e.vld});
      check("b_init_busy", {31'h0, bus_b.init_busy}, {31'h0, e.busy});
      check("b_data_out",  bus_b.data_out,           e.data);
    end
  end

  task automatic run_a();
    vec_a_t tbl[13];
    tbl[0]  = '{1, 1, 4'd0, 8'hCA, 1, 0, 4'd0, 0, 8'h00};
    tbl[1]  = '{1, 1, 4'd7, 8'h5E, 1, 0, 4'd0, 0, 8'h00};
    tbl[2]  = '{1, 0, 4'd0, 8'h00, 1, 1, 4'd0, 1, 8'hCA};
    tbl[3]  = '{1, 0, 4'd0, 8'h00, 1, 1, 4'd7, 1, 8'h5E};
    tbl[4]  = '{0, 1, 4'd0, 8'h00, 1, 1, 4'd0, 0, 8'h00};
    tbl[5]  = '{1, 0, 4'd0, 8'h00, 1, 1, 4'd0, 1, 8'hCA};
    tbl[6]  = '{1, 1, 4'd5, 8'h12, 1, 0, 4'd0, 0, 8'h00};
    tbl[7]  = '{1, 1, 4'd5, 8'h34, 1, 1, 4'd5, 1, 8'h12};
    tbl[8]  = '{1, 0, 4'd0, 8'h00, 1, 1, 4'd5, 1, 8'h34};
    tbl[9]  = '{1, 1, 4'd9, 8'hA5, 1, 1, 4'd7, 1, 8'h5E};
    tbl[10] = '{1, 1, 4'd9, 8'h00, 0, 1, 4'd9, 1, 8'hA5};
    tbl[11] = '{1, 0, 4'd0, 8'h00, 1, 1, 4'd9, 1, 8'hA5};
    tbl[12] = '{1, 0, 4'd0, 8'h00, 1, 0, 4'd0, 0, 8'h00};

    drv_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drv_a(0, 1, 1, 4'd3, 8'hCA, 1, 1, 4'd3, 0, 0);
    for (int i = 0; i < 16; i++)
      drv_a(0, 1, 0, 0, 0, 1, 1, 4'(i), 1, 8'h00);

    for (int i = 0; i < 13; i++)
      drv_a(0, tbl[i].cs, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be,
            tbl[i].re, tbl[i].ra, tbl[i].ev, tbl[i].ed);

    drv_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drv_a(0, 1, 1, 4'(i), 8'h77, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drv_a(0, 1, 0, 0, 0, 1, 1, 4'(i), 1, 8'h00);
    drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_b();
    drv_b(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      drv_b(0, 1, 1, 4'd3, 32'h000000CA, 4'hF, 1, 4'd3, 0, 0);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd3, 1, 32'h00000000);
    drv_b(0, 1, 1, 4'd2,  32'h11223344, 4'hF, 0, 0,    0, 0);
    drv_b(0, 1, 1, 4'd2,  32'hAABBCCDD, 4'h5, 0, 0,    0, 0);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd2, 1, 32'h11BB33DD);
    drv_b(0, 1, 1, 4'd5,  32'h00000012, 4'hF, 0, 0,    0, 0);
    drv_b(0, 1, 1, 4'd5,  32'h00000034, 4'hF, 1, 4'd5, 1, 32'h00000034);
    drv_b(0, 1, 1, 4'd5,  32'hFFFFFFFF, 4'h2, 1, 4'd5, 1, 32'h0000FF34);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd5, 1, 32'h0000FF34);
    drv_b(0, 1, 1, 4'd12, 32'hFFFFFFFF, 4'hF, 0, 0,    0, 0);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd12, 1, 32'h00000000);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd9, 1, 32'h00000000);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd2, 1, 32'h11BB33DD);
    drv_b(0, 1, 1, 4'd9,  32'hDEADBEEF, 4'hF, 0, 0,    0, 0);
    drv_b(0, 1, 0, 0,     0,            4'h0, 1, 4'd9, 1, 32'hDEADBEEF);
    drv_b(0, 0, 0, 0,     0,            4'h0, 0, 0,    0, 0);
  endtask

  initial begin
    bus_a.chip_sel = 0; bus_a.write_enable = 0; bus_a.wr_addr = 0; bus_a.data_in = 0;
    bus_a.byte_en = 0;  bus_a.read_enable = 0;  bus_a.rd_addr = 0;
    bus_b.chip_sel = 0; bus_b.write_enable = 0; bus_b.wr_addr = 0; bus_b.data_in = 0;
    bus_b.byte_en = 0;  bus_b.read_enable = 0;  bus_b.rd_addr = 0;
    fork
      run_a();
      run_b();
    join
    repeat (3) @(posedge ck);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
